// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC tick path: square-wave generator FSM
// encoding and the default half-period derived from the clock frequency.
package rtc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } sqw_state_e;

  // Half-period that yields a 1 Hz square wave from a base_freq clock.
  function automatic int unsigned default_half(input int unsigned base_freq);
    return base_freq / 2;
  endfunction

endpackage

// File: rtl/sqw_phase_cnt.sv
// Loadable down-counter timing one phase of the square wave.
// Load has priority over decrement; the count holds at zero.
module sqw_phase_cnt #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             dec,
  output logic [DIV_W-1:0] cnt,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count: reload at phase boundaries, otherwise step toward zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sqw_gen.sv
// Programmable 50%-duty square-wave generator with rising-edge strobe.
// A shadow half-period is sampled only when a new period starts, so
// software updates never distort a period already in progress.
module sqw_gen
  import rtc_pkg::*;
#(
  parameter int unsigned BASE_FREQ = 10_000_000,
  parameter int          DIV_W     = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] half_period,
  output logic             sqw,
  output logic             rise,
  output logic             active,
  output logic             cfg_err
);

  localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(default_half(BASE_FREQ));

  sqw_state_e       state_q, state_d;
  logic             sqw_q, sqw_d;
  logic             rise_q, rise_d;
  logic             cfg_err_q, cfg_err_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] cur_half_q, cur_half_d;

  logic             cnt_ld;
  logic [DIV_W-1:0] cnt_ld_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [DIV_W-1:0] cnt_val;
  logic             do_start;

  sqw_phase_cnt #(.DIV_W(DIV_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  // Next-state, shadow and counter control; a start (from IDLE or at the
  // end of LOW) always latches the shadow value held before this edge.
  always_comb begin
    state_d    = state_q;
    sqw_d      = sqw_q;
    rise_d     = 1'b0;
    cfg_err_d  = cfg_err_q;
    shadow_d   = shadow_q;
    cur_half_d = cur_half_q;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    cnt_dec    = 1'b0;
    do_start   = 1'b0;

    if (load) begin
      shadow_d = half_period;
      if (half_period != '0) cfg_err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (en) begin
          if (shadow_q != '0) do_start  = 1'b1;
          else                cfg_err_d = 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_zero) begin
          state_d    = S_LOW;
          sqw_d      = 1'b0;
          cnt_ld     = 1'b1;
          cnt_ld_val = cur_half_q - DIV_W'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_LOW: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (en && (shadow_q != '0)) begin
          do_start = 1'b1;
        end else begin
          state_d = S_IDLE;
          sqw_d   = 1'b0;
          if (en) cfg_err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sqw_d   = 1'b0;
      end
    endcase

    if (do_start) begin
      state_d    = S_HIGH;
      sqw_d      = 1'b1;
      rise_d     = 1'b1;
      cur_half_d = shadow_q;
      cnt_ld     = 1'b1;
      cnt_ld_val = shadow_q - DIV_W'(1);
    end
  end

  // Control and configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sqw_q      <= 1'b0;
      rise_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      shadow_q   <= DEF_HALF;
      cur_half_q <= DEF_HALF;
    end else begin
      state_q    <= state_d;
      sqw_q      <= sqw_d;
      rise_q     <= rise_d;
      cfg_err_q  <= cfg_err_d;
      shadow_q   <= shadow_d;
      cur_half_q <= cur_half_d;
    end
  end

  assign sqw     = sqw_q;
  assign rise    = rise_q;
  assign active  = (state_q != S_IDLE);
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_sqw_gen.sv
// Directed bench for sqw_gen (BASE_FREQ=20, DIV_W=8). Expected per-cycle
// {sqw, rise, active, cfg_err} words are queued as stimulus is applied and
// checked against the DUT on every falling edge while the queue is non-empty.
module tb_sqw_gen;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             load;
  logic [DIV_W-1:0] half_period;
  logic             sqw;
  logic             rise;
  logic             active;
  logic             cfg_err;

  int n_chk  = 0;
  int n_fail = 0;
  int sb_idx = 0;

  logic [3:0] exp_q[$];

  sqw_gen #(.BASE_FREQ(20), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .half_period (half_period),
    .sqw         (sqw),
    .rise        (rise),
    .active      (active),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard check on the falling edge
  always @(negedge clk) begin
    logic [3:0] obs;
    logic [3:0] e;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      obs = {sqw, rise, active, cfg_err};
      n_chk++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL sb[%0d] {sqw,rise,active,cfg_err} observed=%b expected=%b", sb_idx, obs, e);
      end
      sb_idx++;
    end
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] e);
    n_chk++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic push(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // One full period of half-period h: rise on the first HIGH cycle only.
  task automatic push_period(input int h);
    push(4'b1110, 1);
    push(4'b1010, h - 1);
    push(4'b0010, h);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s drain: entries left observed=%0d expected=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; half_period = '0;
    cyc(2);
    check("reset_outputs", {sqw, rise, active, cfg_err}, 4'b0000);
    rst = 1'b0;
    cyc(1);

    // 1: default half-period 10, two periods, stop
    en = 1'b1;
    push(4'b0000, 1); push_period(10); push_period(10); push(4'b0000, 1);
    cyc(25); en = 1'b0;
    wait_drain("t1_default");

    // 2: load 3 mid-HIGH; current period unaffected
    en = 1'b1;
    push(4'b0000, 1); push_period(10); push_period(3); push(4'b0000, 1);
    cyc(3); load = 1'b1; half_period = 8'd3;
    cyc(1); load = 1'b0;
    cyc(20); en = 1'b0;
    wait_drain("t2_load_mid");

    // 3: load 5 on the boundary edge; applies one period later
    en = 1'b1;
    push(4'b0000, 1); push_period(3); push_period(3); push_period(5); push(4'b0000, 1);
    cyc(6); load = 1'b1; half_period = 8'd5;
    cyc(1); load = 1'b0;
    cyc(14); en = 1'b0;
    wait_drain("t3_load_boundary");

    // 4a: en dropped in HIGH; period completes, then IDLE
    en = 1'b1;
    push(4'b0000, 1); push_period(5); push(4'b0000, 1);
    cyc(2); en = 1'b0;
    wait_drain("t4_stop");

    // 4b: en re-raised during LOW continues seamlessly
    en = 1'b1;
    push(4'b0000, 1); push_period(5); push_period(5); push(4'b0000, 1);
    cyc(2); en = 1'b0;
    cyc(5); en = 1'b1;
    cyc(8); en = 1'b0;
    wait_drain("t4_reraise");

    // 5: zero shadow -> cfg_err, then load 4 clears it and starts 4/4
    load = 1'b1; half_period = 8'd0;
    cyc(1); load = 1'b0; en = 1'b1;
    push(4'b0000, 1); push(4'b0001, 2);
    cyc(2); en = 1'b0; load = 1'b1; half_period = 8'd4;
    cyc(1); load = 1'b0; en = 1'b1;
    push(4'b0000, 1); push_period(4); push(4'b0000, 1);
    cyc(2); en = 1'b0;
    wait_drain("t5_cfg_err");

    // 6: half-period 1 toggles every cycle
    load = 1'b1; half_period = 8'd1;
    cyc(1); load = 1'b0; en = 1'b1;
    push(4'b0000, 1); push_period(1); push_period(1); push_period(1); push(4'b0000, 1);
    cyc(5); en = 1'b0;
    wait_drain("t6_half1");

    // 6: async reset mid-HIGH drops sqw immediately
    load = 1'b1; half_period = 8'd6;
    cyc(1); load = 1'b0; en = 1'b1;
    cyc(3);
    check("pre_rst_high", {sqw, rise, active, cfg_err}, 4'b1010);
    #2; rst = 1'b1;
    #1;
    check("async_rst", {sqw, rise, active, cfg_err}, 4'b0000);
    en = 1'b0;
    cyc(1); rst = 1'b0;
    cyc(1);

    // first period after reset uses the default half-period again
    en = 1'b1;
    push(4'b0000, 1); push_period(10); push(4'b0000, 1);
    cyc(5); en = 1'b0;
    wait_drain("t6_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
